mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDRWIDTH, default 16, address width of main memory port.
REQ-002 Parameter DATAWIDTH, default 8, data width of main memory port.
REQ-003 Parameter STARVE_MAX, default 8, consecutive ungranted DMA request cycles before forced DMA grant (legal 1..255).
REQ-004 clk  in  1  single clock; CPU port of main memory runs on it.
REQ-005 nRst  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  CPU requests a memory access this cycle.
REQ-007 cpu_we  in  1  CPU access is a write (1) or read (0).
REQ-008 cpu_addr  in  ADDRWIDTH  CPU address.
REQ-009 cpu_wdata  in  DATAWIDTH  CPU write data.
REQ-010 cpu_rdy  out  1  CPU request accepted this cycle; drives M65C02 Rdy (0 stalls CPU).
REQ-011 cpu_rdata  out  DATAWIDTH  CPU read data.
REQ-012 cpu_rvalid  out  1  cpu_rdata valid this cycle.
REQ-013 dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDRWIDTH/DATAWIDTH  DMA (serial loader) request, same meaning as CPU fields.
REQ-014 dma_hold  in  1  DMA asserts bus ownership lock; CPU locked out while set.
REQ-015 dma_gnt  out  1  DMA request accepted this cycle.
REQ-016 dma_rdata, dma_rvalid  out  DATAWIDTH/1  DMA read data and valid.
REQ-017 mem_we, mem_addr, mem_wdata  out  1/ADDRWIDTH/DATAWIDTH  registered command to rwport_byte_sram port A.
REQ-018 mem_rdata  in  DATAWIDTH  SRAM read data, valid one cycle after command cycle.

Function
REQ-019 FSM states: IDLE, CPU, DMA, LOCK; state = owner of last accepted access.
REQ-020 At most one grant (cpu_rdy or dma_gnt) per cycle; cpu_rdy and dma_gnt combinational from state, requests, starvation counter.
REQ-021 cpu_rdy = 1 whenever cpu_req = 0 and state != LOCK (idle CPU never stalled).
REQ-022 Priority in IDLE/CPU/DMA: CPU wins, unless starve_cnt = STARVE_MAX and dma_req = 1, then DMA wins.
REQ-023 starve_cnt (8 bit): increments when dma_req = 1 and dma_gnt = 0, saturates at STARVE_MAX, clears on dma_gnt or dma_req = 0.
REQ-024 Transitions: grant to CPU -> CPU; grant to DMA with dma_hold = 0 -> DMA; grant to DMA with dma_hold = 1 -> LOCK; no request -> IDLE.
REQ-025 LOCK: cpu_rdy = 0 regardless of cpu_req; dma_gnt = dma_req; exit to IDLE when dma_hold = 0 (same cycle release, CPU may be granted next cycle).
REQ-026 dma_hold asserted outside LOCK only takes effect on next DMA grant; never preempts a CPU grant in the same cycle.
REQ-027 Grant in cycle N: mem_we/addr/wdata registered at edge ending N (command cycle N+1); mem_we = 0 on cycles with no grant.
REQ-028 Read granted in cycle N: rdata returned on owner's port with rvalid = 1 in cycle N+2, exactly one cycle; writes produce no rvalid.
REQ-029 Owner tag pipelined two stages with the command; rdata of the other port held at last value, its rvalid = 0.
REQ-030 Back-to-back accesses from either port at one per cycle sustained; no bubble on owner switch.

Reset
REQ-031 nRst low asynchronously: state = IDLE, starve_cnt = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, both rvalid = 0, both rdata = 0, pipeline tags cleared.
REQ-032 Accesses in flight at reset are discarded; no rvalid after deassertion for pre-reset requests.
REQ-033 While nRst low, cpu_rdy = 0 and dma_gnt = 0.

Structure
REQ-034 Shared package zed_mem_pkg: state encoding constants (IDLE, CPU, DMA, LOCK), owner tag constants, default ADDRWIDTH/DATAWIDTH.
REQ-035 One sub-module, arb_starve_ctr (saturating starvation counter); FSM and read-return pipeline in mem_arbiter.

Verification
REQ-036 CPU read 0x1234 alone, SRAM preloaded 0xA5 -> cpu_rdy = 1 cycle N, mem_addr = 0x1234 cycle N+1, cpu_rvalid = 1 with 0xA5 cycle N+2.
REQ-037 CPU and DMA request continuously, STARVE_MAX = 8 -> 8 CPU grants then 1 DMA grant, pattern repeats; never simultaneous grants.
REQ-038 DMA writes 0x00..0x0F to 0x0200..0x020F with dma_hold = 1, CPU requesting -> cpu_rdy = 0 throughout, 16 consecutive dma_gnt, CPU granted cycle after dma_hold falls; CPU readback matches.
REQ-039 Alternating CPU read / DMA read each cycle -> each rvalid pulses on correct port only, data matching address, zero bubbles.
REQ-040 nRst pulsed low the cycle after a DMA read grant -> all outputs at reset values immediately, no dma_rvalid after release, state IDLE.
REQ-041 cpu_req = 0, dma_req = 0 -> cpu_rdy = 1, mem_we = 0, starve_cnt = 0.

Source files
------------

// File: rtl/zed_mem_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, read-return
// owner tags and default bus widths.
package zed_mem_pkg;

   localparam int ADDRWIDTH_DEF = 16;
   localparam int DATAWIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CPU  = 2'd1,
      DMA  = 2'd2,
      LOCK = 2'd3
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (CPU, DMA loader) and SRAM port A.
interface mem_arbiter_if #(
   parameter int ADDRWIDTH = 16,
   parameter int DATAWIDTH = 8
);
   logic                 cpu_req;
   logic                 cpu_we;
   logic [ADDRWIDTH-1:0] cpu_addr;
   logic [DATAWIDTH-1:0] cpu_wdata;
   logic                 cpu_rdy;
   logic [DATAWIDTH-1:0] cpu_rdata;
   logic                 cpu_rvalid;

   logic                 dma_req;
   logic                 dma_we;
   logic [ADDRWIDTH-1:0] dma_addr;
   logic [DATAWIDTH-1:0] dma_wdata;
   logic                 dma_hold;
   logic                 dma_gnt;
   logic [DATAWIDTH-1:0] dma_rdata;
   logic                 dma_rvalid;

   logic                 mem_we;
   logic [ADDRWIDTH-1:0] mem_addr;
   logic [DATAWIDTH-1:0] mem_wdata;
   logic [DATAWIDTH-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_we, dma_addr, dma_wdata, dma_hold,
      input  mem_rdata,
      output cpu_rdy, cpu_rdata, cpu_rvalid,
      output dma_gnt, dma_rdata, dma_rvalid,
      output mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_we, dma_addr, dma_wdata, dma_hold,
      output mem_rdata,
      input  cpu_rdy, cpu_rdata, cpu_rvalid,
      input  dma_gnt, dma_rdata, dma_rvalid,
      input  mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles the DMA port has been kept waiting.
module arb_starve_ctr #(
   parameter int STARVE_MAX = 8
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] cnt
);
   localparam logic [7:0] MAX_C = 8'(STARVE_MAX);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != MAX_C))
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA loader) arbiter for a single SRAM port with starvation
// guard, DMA bus lock and a two-stage read-return pipeline.
//
//   state | meaning
//   IDLE  | no access accepted last cycle
//   CPU   | last accepted access was the CPU's
//   DMA   | last accepted access was the DMA's (no lock)
//   LOCK  | DMA holds the bus; CPU stalled until dma_hold drops
module mem_arbiter
   import zed_mem_pkg::*;
#(
   parameter int ADDRWIDTH  = ADDRWIDTH_DEF,
   parameter int DATAWIDTH  = DATAWIDTH_DEF,
   parameter int STARVE_MAX = 8
) (
   input  logic         clk,
   input  logic         nRst,
   mem_arbiter_if.slave bus
);
   arb_state_e           state_q, state_d;
   logic [7:0]           starve_cnt;
   logic                 starve_sat;
   logic                 dma_win;
   logic                 cpu_gnt;
   logic                 dma_gnt;
   logic                 cpu_rdy;

   logic                 mem_we_q, mem_we_d;
   logic [ADDRWIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATAWIDTH-1:0] mem_wdata_q, mem_wdata_d;
   owner_e               tag1_q, tag1_d;
   owner_e               tag2_q, tag2_d;
   logic [DATAWIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATAWIDTH-1:0] dma_rdata_q, dma_rdata_d;

   assign starve_sat = (starve_cnt == 8'(STARVE_MAX));

   arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
      .clk  (clk),
      .nRst (nRst),
      .inc  (bus.dma_req & ~dma_gnt),
      .clr  (~bus.dma_req | dma_gnt),
      .cnt  (starve_cnt)
   );

   // grants are purely combinational so the CPU sees Rdy in the request cycle
   always_comb begin
      state_d = state_q;
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      cpu_rdy = 1'b0;
      dma_win = bus.dma_req && starve_sat;
      if (nRst) begin
         if (state_q == LOCK) begin
            dma_gnt = bus.dma_req;
            if (!bus.dma_hold) state_d = IDLE;
         end else begin
            cpu_gnt = bus.cpu_req && !dma_win;
            dma_gnt = bus.dma_req && (dma_win || !bus.cpu_req);
            cpu_rdy = !bus.cpu_req || cpu_gnt;
            if (cpu_gnt)      state_d = CPU;
            else if (dma_gnt) state_d = bus.dma_hold ? LOCK : DMA;
            else              state_d = IDLE;
         end
      end
   end

   always_comb begin
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      tag1_d      = OWN_NONE;
      if (cpu_gnt) begin
         mem_we_d    = bus.cpu_we;
         mem_addr_d  = bus.cpu_addr;
         mem_wdata_d = bus.cpu_wdata;
         tag1_d      = bus.cpu_we ? OWN_NONE : OWN_CPU;
      end else if (dma_gnt) begin
         mem_we_d    = bus.dma_we;
         mem_addr_d  = bus.dma_addr;
         mem_wdata_d = bus.dma_wdata;
         tag1_d      = bus.dma_we ? OWN_NONE : OWN_DMA;
      end
      tag2_d      = tag1_q;
      cpu_rdata_d = (tag2_q == OWN_CPU) ? bus.mem_rdata : cpu_rdata_q;
      dma_rdata_d = (tag2_q == OWN_DMA) ? bus.mem_rdata : dma_rdata_q;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q     <= IDLE;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         tag1_q      <= OWN_NONE;
         tag2_q      <= OWN_NONE;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag2_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   // returning read data passes straight through; the idle port keeps its last value
   assign bus.cpu_rdy    = cpu_rdy;
   assign bus.dma_gnt    = dma_gnt;
   assign bus.cpu_rvalid = (tag2_q == OWN_CPU);
   assign bus.dma_rvalid = (tag2_q == OWN_DMA);
   assign bus.cpu_rdata  = (tag2_q == OWN_CPU) ? bus.mem_rdata : cpu_rdata_q;
   assign bus.dma_rdata  = (tag2_q == OWN_DMA) ? bus.mem_rdata : dma_rdata_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: SRAM model, shadow memory and expected read returns.
module tb_mem_arbiter;
   import zed_mem_pkg::*;

   localparam int SM = 8;

   logic clk;
   logic nRst;
   int   total;
   int   bad;
   int   cyc;

   mem_arbiter_if #(.ADDRWIDTH(16), .DATAWIDTH(8)) bus ();

   mem_arbiter #(.ADDRWIDTH(16), .DATAWIDTH(8), .STARVE_MAX(SM)) dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus)
   );

   logic [7:0] sram   [0:65535];
   logic [7:0] shadow [0:65535];

   typedef struct {
      int         cyc;
      bit         dma;
      logic [7:0] data;
   } exp_t;

   exp_t sbq[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM port A: registered read, data valid the cycle after the command
   always @(posedge clk) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= sram[bus.mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor: read-return scoreboard, shadow memory, single-grant check
   exp_t mon_e;
   bit   mon_cv, mon_dv;
   always @(negedge clk) begin
      cyc++;
      if (!nRst) begin
         sbq.delete();
      end else begin
         mon_cv = 1'b0;
         mon_dv = 1'b0;
         if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            mon_e = sbq.pop_front();
            mon_cv = !mon_e.dma;
            mon_dv = mon_e.dma;
         end
         chk("rvalid_pair", {30'd0, bus.cpu_rvalid, bus.dma_rvalid}, {30'd0, mon_cv, mon_dv});
         if (mon_cv) chk("cpu_rdata", bus.cpu_rdata, mon_e.data);
         if (mon_dv) chk("dma_rdata", bus.dma_rdata, mon_e.data);
         chk("one_grant", bus.cpu_req & bus.cpu_rdy & bus.dma_gnt, 0);
         if (bus.cpu_req && bus.cpu_rdy) begin
            if (bus.cpu_we) shadow[bus.cpu_addr] = bus.cpu_wdata;
            else sbq.push_back('{cyc + 2, 1'b0, shadow[bus.cpu_addr]});
         end else if (bus.dma_req && bus.dma_gnt) begin
            if (bus.dma_we) shadow[bus.dma_addr] = bus.dma_wdata;
            else sbq.push_back('{cyc + 2, 1'b1, shadow[bus.dma_addr]});
         end
      end
   end

   task automatic idle_inputs();
      bus.cpu_req  = 1'b0;
      bus.cpu_we   = 1'b0;
      bus.dma_req  = 1'b0;
      bus.dma_we   = 1'b0;
      bus.dma_hold = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cpu_rdy"},    bus.cpu_rdy, 0);
      chk({tag, "_dma_gnt"},    bus.dma_gnt, 0);
      chk({tag, "_mem_we"},     bus.mem_we, 0);
      chk({tag, "_mem_addr"},   bus.mem_addr, 0);
      chk({tag, "_mem_wdata"},  bus.mem_wdata, 0);
      chk({tag, "_rvalid"},     {bus.cpu_rvalid, bus.dma_rvalid}, 0);
      chk({tag, "_cpu_rdata"},  bus.cpu_rdata, 0);
      chk({tag, "_dma_rdata"},  bus.dma_rdata, 0);
      chk({tag, "_state"},      dut.state_q, IDLE);
   endtask

   int   model_cnt;
   bit   exp_dma;
   int   gnt_run;
   logic [15:0] a;

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      nRst  = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.dma_addr  = '0;
      bus.dma_wdata = '0;
      idle_inputs();
      for (int i = 0; i < 65536; i++) begin
         sram[i]   = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
         shadow[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
      end
      sram[16'h1234]   = 8'hA5;
      shadow[16'h1234] = 8'hA5;

      // reset values, then both ports idle
      @(negedge clk);
      chk_reset_outputs("rst");
      tick();
      nRst = 1'b1;
      @(negedge clk);
      chk("idle_cpu_rdy", bus.cpu_rdy, 1);
      chk("idle_dma_gnt", bus.dma_gnt, 0);
      chk("idle_mem_we", bus.mem_we, 0);
      chk("idle_starve", dut.starve_cnt, 0);
      tick();

      // lone CPU read of 0x1234
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
      @(negedge clk);
      chk("rd1_cpu_rdy", bus.cpu_rdy, 1);
      tick();
      idle_inputs();
      @(negedge clk);
      chk("rd1_mem_addr", bus.mem_addr, 16'h1234);
      chk("rd1_mem_we", bus.mem_we, 0);
      chk("rd1_rvalid_early", bus.cpu_rvalid, 0);
      tick();
      @(negedge clk);
      chk("rd1_rvalid", bus.cpu_rvalid, 1);
      chk("rd1_rdata", bus.cpu_rdata, 8'hA5);
      tick();

      // both ports requesting continuously: SM CPU grants then one DMA grant
      model_cnt = 0;
      for (int i = 0; i < 3 * (SM + 1); i++) begin
         bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0100 + 16'(i);
         bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0300 + 16'(i);
         exp_dma = (model_cnt == SM);
         @(negedge clk);
         chk("starve_cpu_rdy", bus.cpu_rdy, !exp_dma);
         chk("starve_dma_gnt", bus.dma_gnt, exp_dma);
         model_cnt = exp_dma ? 0 : ((model_cnt < SM) ? model_cnt + 1 : SM);
         tick();
      end
      idle_inputs();
      tick();

      // dma_hold outside LOCK never steals a CPU grant
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
      bus.dma_req = 1'b1; bus.dma_hold = 1'b1; bus.dma_addr = 16'h0020;
      @(negedge clk);
      chk("hold_cpu_rdy", bus.cpu_rdy, 1);
      chk("hold_dma_gnt", bus.dma_gnt, 0);
      tick();
      idle_inputs();
      tick();

      // locked DMA burst write 0x0200..0x020F while CPU keeps requesting
      gnt_run = 0;
      for (int i = 0; i < 16; i++) begin
         bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_hold = 1'b1;
         bus.dma_addr = 16'h0200 + 16'(i); bus.dma_wdata = 8'(i);
         bus.cpu_req = (i != 0); bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0200;
         @(negedge clk);
         if (bus.dma_gnt) gnt_run++;
         if (i != 0) chk("lock_cpu_rdy", bus.cpu_rdy, 0);
         tick();
      end
      chk("lock_gnt_run", gnt_run, 16);
      bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_hold = 1'b0;
      @(negedge clk);
      chk("lock_release_cpu_rdy", bus.cpu_rdy, 0);
      tick();
      for (int i = 0; i < 16; i++) begin
         bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0200 + 16'(i);
         @(negedge clk);
         chk("readback_cpu_rdy", bus.cpu_rdy, 1);
         if (i == 0) chk("readback_state", dut.state_q, IDLE);
         tick();
      end
      idle_inputs();
      tick();
      tick();
      chk("readback_mem_0207", sram[16'h0207], 8'h07);

      // alternating CPU / DMA reads, one per cycle
      for (int i = 0; i < 16; i++) begin
         a = 16'($urandom_range(0, 65535));
         bus.cpu_req = (i % 2 == 0); bus.cpu_we = 1'b0; bus.cpu_addr = a;
         bus.dma_req = (i % 2 == 1); bus.dma_we = 1'b0; bus.dma_addr = a;
         @(negedge clk);
         chk("alt_grant", {30'd0, bus.cpu_req & bus.cpu_rdy, bus.dma_gnt},
             (i % 2 == 0) ? 32'd2 : 32'd1);
         tick();
      end
      idle_inputs();

      // reset pulsed the cycle after a DMA read grant
      tick();
      tick();
      bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0300;
      @(negedge clk);
      chk("rstpulse_dma_gnt", bus.dma_gnt, 1);
      tick();
      idle_inputs();
      nRst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("rstpulse");
      tick();
      nRst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_dma_rvalid", bus.dma_rvalid, 0);
         tick();
      end

      chk("sb_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
